btn_debounce: RTL and testbench

Multi-channel push-button debouncer that sits directly downstream of the clock divider in the state-machine lab design. It takes the divider's slow square wave `clk_div` as a sampling strobe, not as a clock. It synchronizes and debounces the raw button inputs and hands the state machine clean levels plus single-cycle press/release pulses, all in the `clk` domain.

---
 rtl/btn_debounce.sv | 140 ++++++++++++++
 tb/tb_btn_debounce.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : btn_debounce                                                    |
// | Purpose  : multi-channel push-button debouncer sampled by a divided strobe |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module btn_debounce #(
  parameter int NUM_BTN        = 4,
  parameter int STABLE_SAMPLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_div,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  // Bit 1 of the state doubles as the debounced level.
  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] PRESSED      = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  localparam logic [3:0] CNT_LAST = 4'(STABLE_SAMPLES - 1);

  logic s1;
  logic s2;
  logic s3;
  logic tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= clk_div;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick = s2 & ~s3;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    logic       sync0;
    logic       smp;
    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic       level;
    logic       press;
    logic       rel;
    logic       press_nxt;
    logic       rel_nxt;

    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      press_nxt = 1'b0;
      rel_nxt   = 1'b0;
      case (state)
        IDLE: begin
          if (smp) begin
            state_nxt = PRESS_WAIT;
            cnt_nxt   = 4'd1;
          end
        end
        PRESS_WAIT: begin
          if (!smp) begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = PRESSED;
            cnt_nxt   = 4'd0;
            press_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
        end
        PRESSED: begin
          if (!smp) begin
            state_nxt = RELEASE_WAIT;
            cnt_nxt   = 4'd1;
          end
        end
        RELEASE_WAIT: begin
          if (smp) begin
            state_nxt = PRESSED;
            cnt_nxt   = 4'd0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
            rel_nxt   = 1'b1;
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end
      endcase
    end

    // Pulses clear every cycle; since tick lasts one cycle they are one cycle wide.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync0 <= 1'b0;
        smp   <= 1'b0;
        state <= IDLE;
        cnt   <= 4'd0;
        level <= 1'b0;
        press <= 1'b0;
        rel   <= 1'b0;
      end else begin
        sync0 <= btn_raw[i];
        smp   <= sync0;
        press <= 1'b0;
        rel   <= 1'b0;
        if (tick) begin
          state <= state_nxt;
          cnt   <= cnt_nxt;
          level <= state_nxt[1];
          press <= press_nxt;
          rel   <= rel_nxt;
        end
      end
    end

    assign btn_level[i]   = level;
    assign btn_press[i]   = press;
    assign btn_release[i] = rel;
  end

endmodule
`default_nettype wire

// File: tb/tb_btn_debounce.sv
`default_nettype none
// Bench for btn_debounce: directed scenarios plus random button activity,
// every cycle compared against a run-length reference model.
module tb_btn_debounce;

  localparam int NUM_BTN = 4;
  localparam int STABLE  = 4;

  logic               clk     = 1'b0;
  logic               rst     = 1'b0;
  logic               clk_div = 1'b0;
  logic [NUM_BTN-1:0] btn_raw = '0;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;

  int checks   = 0;
  int failures = 0;

  btn_debounce #(
    .NUM_BTN       (NUM_BTN),
    .STABLE_SAMPLES(STABLE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_div    (clk_div),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  // clk_div: period 8 clk, 4 high / 4 low
  bit div_run = 1'b0;
  int div_ph  = 0;
  always @(negedge clk) begin
    if (div_run) begin
      div_ph  = (div_ph + 1) % 8;
      clk_div = (div_ph < 4);
    end else begin
      div_ph  = 0;
      clk_div = 1'b0;
    end
  end

  // Reference: inputs reach the decision two edges late; a strobe is a
  // rising clk_div seen two edges late. On each strobe, count consecutive
  // samples that disagree with the accepted level; flip after STABLE of them.
  logic [NUM_BTN-1:0] raw_h1, raw_h2;
  logic               div_h1, div_h2, div_h3;
  int                 run [NUM_BTN];
  logic [NUM_BTN-1:0] m_level, m_press, m_release;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_h1 = '0; raw_h2 = '0;
      div_h1 = 1'b0; div_h2 = 1'b0; div_h3 = 1'b0;
      m_level = '0; m_press = '0; m_release = '0;
      for (int i = 0; i < NUM_BTN; i++) run[i] = 0;
    end else begin
      m_press   = '0;
      m_release = '0;
      if (div_h2 && !div_h3) begin
        for (int i = 0; i < NUM_BTN; i++) begin
          if (raw_h2[i] != m_level[i]) begin
            run[i]++;
            if (run[i] == STABLE) begin
              run[i] = 0;
              m_level[i] = ~m_level[i];
              if (m_level[i]) m_press[i] = 1'b1;
              else            m_release[i] = 1'b1;
            end
          end else begin
            run[i] = 0;
          end
        end
      end
      div_h3 = div_h2; div_h2 = div_h1; div_h1 = clk_div;
      raw_h2 = raw_h1; raw_h1 = btn_raw;
    end
  end

  int pcnt [NUM_BTN];
  int rcnt [NUM_BTN];
  bit all_press_seen = 1'b0;

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      checks++;
      assert ({btn_level, btn_press, btn_release} === {m_level, m_press, m_release})
      else begin
        failures++;
        $error("FAIL model_cmp t=%0t level/press/release observed=%b/%b/%b expected=%b/%b/%b",
               $time, btn_level, btn_press, btn_release, m_level, m_press, m_release);
      end
      for (int i = 0; i < NUM_BTN; i++) begin
        if (btn_press[i] === 1'b1)   pcnt[i]++;
        if (btn_release[i] === 1'b1) rcnt[i]++;
      end
      if (btn_press === 4'hF) all_press_seen = 1'b1;
    end
  endtask

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int p3;

  initial begin
    for (int i = 0; i < NUM_BTN; i++) begin pcnt[i] = 0; rcnt[i] = 0; end

    // Reset with clk_div held low
    #1 rst = 1'b1;
    step(3);
    expect_eq("reset_outputs", {btn_level, btn_press, btn_release}, 32'd0);
    rst = 1'b0;
    div_run = 1'b1;
    step(100);
    expect_eq("idle_no_press", pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3], 0);
    expect_eq("idle_no_release", rcnt[0] + rcnt[1] + rcnt[2] + rcnt[3], 0);

    // Clean press on channel 0
    btn_raw[0] = 1'b1;
    step(60);
    expect_eq("ch0_press_once", pcnt[0], 1);
    expect_eq("ch0_level", {28'd0, btn_level}, 32'h1);
    expect_eq("ch0_others_quiet", pcnt[1] + pcnt[2] + pcnt[3], 0);

    // Bouncing channel 1
    for (int r = 0; r < 2; r++) begin
      btn_raw[1] = 1'b1; step(8);
      btn_raw[1] = 1'b0; step(8);
    end
    expect_eq("ch1_bounce_quiet", pcnt[1], 0);
    btn_raw[1] = 1'b1;
    step(60);
    expect_eq("ch1_press_once", pcnt[1], 1);

    // Channel 2: short release glitch rejected, long release accepted
    btn_raw[2] = 1'b1;
    step(60);
    expect_eq("ch2_press", pcnt[2], 1);
    btn_raw[2] = 1'b0; step(24);
    btn_raw[2] = 1'b1; step(60);
    expect_eq("ch2_glitch_no_release", rcnt[2], 0);
    expect_eq("ch2_level_held", btn_level[2], 1);
    btn_raw[2] = 1'b0; step(60);
    expect_eq("ch2_release_once", rcnt[2], 1);
    expect_eq("ch2_level_low", btn_level[2], 0);

    // All channels pressed in one cycle
    btn_raw = '0; step(60);
    expect_eq("all_released", {28'd0, btn_level}, 32'h0);
    all_press_seen = 1'b0;
    btn_raw = 4'hF; step(60);
    expect_eq("simultaneous_press", all_press_seen, 1);
    expect_eq("all_level_high", {28'd0, btn_level}, 32'hF);

    // Reset mid-qualification on channel 3
    btn_raw = '0; step(60);
    p3 = pcnt[3];
    btn_raw[3] = 1'b1;
    for (int k = 0; k < 40 && run[3] != 2; k++) step(1);
    expect_eq("ch3_two_ticks_reached", run[3], 2);
    #2 rst = 1'b1;
    #1 expect_eq("rst_async_clear", {btn_level, btn_press, btn_release}, 32'd0);
    step(5);
    rst = 1'b0;
    step(24);
    expect_eq("ch3_no_early_press", pcnt[3], p3);
    step(40);
    expect_eq("ch3_press_after_full_qual", pcnt[3], p3 + 1);

    // Random activity
    for (int it = 0; it < 250; it++) begin
      btn_raw = 4'($urandom_range(0, 15));
      step($urandom_range(1, 40));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
